// File: rtl/aes_pkg.sv
// Shared AES-128 inverse-cipher helpers: constants, inverse S-box and inverse round transforms.
// Byte k of a 128-bit state sits at bits [127-8k -: 8]; bytes are column-major (row + 4*col).
package aes_pkg;

    localparam int NR   = 10;
    localparam int KS_W = 128 * (NR + 1);

    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } dec_state_t;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] fn_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] fn_mul9(input logic [7:0] b);
        return fn_xtime(fn_xtime(fn_xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] fn_mul11(input logic [7:0] b);
        return fn_xtime(fn_xtime(fn_xtime(b))) ^ fn_xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] fn_mul13(input logic [7:0] b);
        return fn_xtime(fn_xtime(fn_xtime(b))) ^ fn_xtime(fn_xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] fn_mul14(input logic [7:0] b);
        return fn_xtime(fn_xtime(fn_xtime(b))) ^ fn_xtime(fn_xtime(b)) ^ fn_xtime(b);
    endfunction

    function automatic aes_state_t fn_inv_sub_bytes(input aes_state_t s);
        aes_state_t r;
        for (int k = 0; k < 16; k++) begin
            r[8*k +: 8] = INV_SBOX[s[8*k +: 8]];
        end
        return r;
    endfunction

    // Row r rotates right by r columns.
    function automatic aes_state_t fn_inv_shift_rows(input aes_state_t s);
        aes_state_t r;
        for (int row = 0; row < 4; row++) begin
            for (int col = 0; col < 4; col++) begin
                r[8*(15-(row+4*col)) +: 8] = s[8*(15-(row+4*((col+4-row)%4))) +: 8];
            end
        end
        return r;
    endfunction

    function automatic aes_state_t fn_inv_mix_columns(input aes_state_t s);
        aes_state_t r;
        logic [7:0] a0, a1, a2, a3;
        for (int col = 0; col < 4; col++) begin
            a0 = s[8*(15-4*col) +: 8];
            a1 = s[8*(14-4*col) +: 8];
            a2 = s[8*(13-4*col) +: 8];
            a3 = s[8*(12-4*col) +: 8];
            r[8*(15-4*col) +: 8] = fn_mul14(a0) ^ fn_mul11(a1) ^ fn_mul13(a2) ^ fn_mul9(a3);
            r[8*(14-4*col) +: 8] = fn_mul9(a0)  ^ fn_mul14(a1) ^ fn_mul11(a2) ^ fn_mul13(a3);
            r[8*(13-4*col) +: 8] = fn_mul13(a0) ^ fn_mul9(a1)  ^ fn_mul14(a2) ^ fn_mul11(a3);
            r[8*(12-4*col) +: 8] = fn_mul11(a0) ^ fn_mul13(a1) ^ fn_mul9(a2)  ^ fn_mul14(a3);
        end
        return r;
    endfunction

    function automatic aes_state_t fn_round_key(input logic [KS_W-1:0] ks, input logic [3:0] n);
        return ks[{n, 7'd0} +: 128];
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round; i_final drops InvMixColumns for the last round.
module aes_inv_round
    import aes_pkg::*;
(
    input  aes_state_t state,
    input  aes_state_t round_key,
    input  logic       i_final,
    output aes_state_t next_state
);

    aes_state_t keyed_s;

    assign keyed_s    = fn_inv_sub_bytes(fn_inv_shift_rows(state)) ^ round_key;
    assign next_state = i_final ? keyed_s : fn_inv_mix_columns(keyed_s);

endmodule

// File: rtl/aes_decrypt_iterative.sv
// Iterative AES-128 inverse cipher, one block in flight, valid/ready on both sides.
// Define AES_DEC_UNROLL2_EN to run two inverse rounds per clock.
module aes_decrypt_iterative
    import aes_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [127:0]     i_cipher_text,
    input  logic [KS_W-1:0]  i_key_schedule,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [127:0]     o_plain_text,
    output logic [TAG_W-1:0] o_tag
);

    dec_state_t       fsm_r;
    aes_state_t       blk_r;
    logic [KS_W-1:0]  ks_r;
    logic [3:0]       rnd_r;
    logic [TAG_W-1:0] tag_r;
    aes_state_t       rnd_out_s;
    logic             last_step_s;

`ifdef AES_DEC_UNROLL2_EN
    localparam logic [3:0] RND_STEP = 4'd2;

    aes_state_t rk_hi_s;
    aes_state_t rk_lo_s;
    aes_state_t mid_s;

    // rnd_r is always odd here, so the first datapath never sees the final round.
    assign rk_hi_s     = fn_round_key(ks_r, rnd_r);
    assign rk_lo_s     = fn_round_key(ks_r, rnd_r - 4'd1);
    assign last_step_s = (rnd_r == 4'd1);

    aes_inv_round u_round_hi (
        .state      (blk_r),
        .round_key  (rk_hi_s),
        .i_final    (1'b0),
        .next_state (mid_s)
    );

    aes_inv_round u_round_lo (
        .state      (mid_s),
        .round_key  (rk_lo_s),
        .i_final    (last_step_s),
        .next_state (rnd_out_s)
    );
`else
    localparam logic [3:0] RND_STEP = 4'd1;

    aes_state_t rk_s;

    assign rk_s        = fn_round_key(ks_r, rnd_r);
    assign last_step_s = (rnd_r == 4'd0);

    aes_inv_round u_round (
        .state      (blk_r),
        .round_key  (rk_s),
        .i_final    (last_step_s),
        .next_state (rnd_out_s)
    );
`endif

    // Control FSM, round counter, capture registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_r        <= ST_IDLE;
            blk_r        <= 128'd0;
            ks_r         <= '0;
            rnd_r        <= 4'd0;
            tag_r        <= '0;
            o_ready      <= 1'b0;
            o_valid      <= 1'b0;
            o_plain_text <= 128'd0;
            o_tag        <= '0;
        end else begin
            case (fsm_r)
                ST_IDLE: begin
                    if (!o_ready) begin
                        o_ready <= 1'b1;
                    end else if (i_valid) begin
                        blk_r   <= i_cipher_text ^ i_key_schedule[KS_W-1 -: 128];
                        ks_r    <= i_key_schedule;
                        tag_r   <= i_tag;
                        rnd_r   <= 4'd9;
                        o_ready <= 1'b0;
                        fsm_r   <= ST_ROUND;
                    end else begin
                        fsm_r <= ST_IDLE;
                    end
                end
                ST_ROUND: begin
                    if (last_step_s) begin
                        o_plain_text <= rnd_out_s;
                        o_tag        <= tag_r;
                        o_valid      <= 1'b1;
                        fsm_r        <= ST_DONE;
                    end else begin
                        blk_r <= rnd_out_s;
                        rnd_r <= rnd_r - RND_STEP;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        fsm_r   <= ST_IDLE;
                    end else begin
                        fsm_r <= ST_DONE;
                    end
                end
                default: begin
                    o_valid <= 1'b0;
                    o_ready <= 1'b0;
                    fsm_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decrypt_iterative.sv
// Bench for aes_decrypt_iterative: forward AES-128 model encrypts, DUT must return the plaintext.
module tb_aes_decrypt_iterative;

    localparam int TAG_W = 4;
`ifdef AES_DEC_UNROLL2_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 10;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_valid;
    logic             o_ready;
    logic [127:0]     i_cipher_text;
    logic [1407:0]    i_key_schedule;
    logic [TAG_W-1:0] i_tag;
    logic             o_valid;
    logic             i_ready;
    logic [127:0]     o_plain_text;
    logic [TAG_W-1:0] o_tag;

    always #5 clk = ~clk;

    aes_decrypt_iterative #(.TAG_W(TAG_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_cipher_text  (i_cipher_text),
        .i_key_schedule (i_key_schedule),
        .i_tag          (i_tag),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_plain_text   (o_plain_text),
        .o_tag          (o_tag)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0]       sbox [256];
    logic [127:0]     cur_pt;
    logic [127:0]     exp_pt;
    logic [TAG_W-1:0] exp_tag;
    logic             busy = 1'b0;
    logic             was_rst = 1'b1;
    int               acc_cyc = 0;
    int               rel_cyc = 0;
    int               n_acc = 0;
    int               n_done = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %b want %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0d want %0d", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] b;
        for (int v = 0; v < 256; v++) begin
            b = 8'h01;
            for (int i = 0; i < 254; i++) b = gmul(b, 8'(v));
            sbox[v] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [1407:0] expand(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] ks;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int n = 0; n < 11; n++) ks[128*n +: 128] = {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
        return ks;
    endfunction

    function automatic logic [127:0] encrypt(input logic [1407:0] ks, input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] rk, res;
        rk = ks[127:0];
        for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ rk[127-8*k -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int k = 0; k < 16; k++) t[k] = sbox[s[k]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) s[r+4*c] = t[r+4*((c+r)%4)];
            if (rnd != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            rk = ks[128*rnd +: 128];
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ rk[127-8*k -: 8];
        end
        for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
        return res;
    endfunction

    // Per-cycle compare against the expected protocol and the scoreboarded plaintext.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk1("rst_o_ready", o_ready, 1'b0);
                chk1("rst_o_valid", o_valid, 1'b0);
                chk128("rst_o_plain_text", o_plain_text, 128'd0);
                chk_int("rst_o_tag", int'(o_tag), 0);
                busy    = 1'b0;
                was_rst = 1'b1;
            end else begin
                if (was_rst) begin
                    rel_cyc = cyc;
                    was_rst = 1'b0;
                end
                chk1("o_ready", o_ready, !busy && (cyc > rel_cyc));
                chk1("o_valid", o_valid, busy && (cyc - acc_cyc >= LAT + 1));
                if (o_valid && busy) begin
                    chk128("o_plain_text", o_plain_text, exp_pt);
                    chk_int("o_tag", int'(o_tag), int'(exp_tag));
                end
                if (i_valid && o_ready) begin
                    exp_pt  = cur_pt;
                    exp_tag = i_tag;
                    busy    = 1'b1;
                    acc_cyc = cyc;
                    n_acc++;
                end else if (o_valid && i_ready && busy) begin
                    busy = 1'b0;
                    n_done++;
                end
            end
        end
    endtask

    task automatic present(input logic [1407:0] k, input logic [127:0] c, input logic [127:0] p,
                           input logic [TAG_W-1:0] t);
        i_key_schedule = k;
        i_cipher_text  = c;
        cur_pt         = p;
        i_tag          = t;
    endtask

    task automatic present_random();
        logic [1407:0] k;
        logic [127:0]  p;
        k = expand({$urandom, $urandom, $urandom, $urandom});
        p = {$urandom, $urandom, $urandom, $urandom};
        present(k, encrypt(k, p), p, TAG_W'($urandom));
    endtask

    task automatic send(input logic [1407:0] k, input logic [127:0] c, input logic [127:0] p,
                        input logic [TAG_W-1:0] t);
        int n0, b;
        present(k, c, p, t);
        i_valid = 1'b1;
        n0 = n_acc;
        b = 0;
        while (n_acc == n0 && b < 200) begin
            @(posedge clk);
            b++;
        end
        #1;
        i_valid        = 1'b0;
        i_cipher_text  = {$urandom, $urandom, $urandom, $urandom};
        i_key_schedule = ~i_key_schedule;
        i_tag          = ~i_tag;
        chk_int("accept_count", n_acc, n0 + 1);
    endtask

    task automatic drain(input int stall);
        int n0, b;
        n0 = n_done;
        i_ready = (stall == 0);
        b = 0;
        while (!o_valid && b < 40) begin
            @(negedge clk);
            b++;
        end
        repeat (stall) @(posedge clk);
        #1 i_ready = 1'b1;
        b = 0;
        while (n_done == n0 && b < 40) begin
            @(posedge clk);
            b++;
        end
        #1;
        chk_int("handshake_count", n_done, n0 + 1);
    endtask

    logic [1407:0] ks1, ks2;
    int            first_acc, n0;

    initial begin
        rst_n          = 1'b0;
        i_valid        = 1'b0;
        i_ready        = 1'b1;
        i_cipher_text  = 128'd0;
        i_key_schedule = '0;
        i_tag          = '0;
        cur_pt         = 128'd0;
        exp_pt         = 128'd0;
        exp_tag        = '0;

        build_sbox();
        chk_int("kat_sbox_00", int'(sbox[0]), 32'h63);
        chk_int("kat_sbox_53", int'(sbox[8'h53]), 32'hed);
        ks1 = expand(128'h000102030405060708090a0b0c0d0e0f);
        ks2 = expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        chk128("kat_rk10_b", ks2[1407:1280], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chk128("kat_enc_c1", encrypt(ks1, 128'h00112233445566778899aabbccddeeff),
               128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        chk128("kat_enc_b", encrypt(ks2, 128'h3243f6a8885a308d313198a2e0370734),
               128'h3925841d02dc09fbdc118597196a0b32);

        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Known-answer vectors through the DUT.
        send(ks1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, 4'h5);
        drain(0);
        send(ks2, 128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734, 4'hA);
        drain(0);

        // Backpressure: five stalled cycles with o_valid high.
        present_random();
        send(i_key_schedule, i_cipher_text, cur_pt, i_tag);
        drain(5);

        // i_valid held with fresh data every cycle: the second accept waits for the first handshake.
        i_ready = 1'b1;
        present_random();
        i_valid = 1'b1;
        n0 = n_acc;
        while (n_acc == n0) @(posedge clk);
        first_acc = acc_cyc;
        for (int i = 0; i < 40 && n_acc == n0 + 1; i++) begin
            #1 present_random();
            @(posedge clk);
        end
        #1 i_valid = 1'b0;
        chk_int("second_accept_count", n_acc, n0 + 2);
        chk_int("accept_spacing", acc_cyc - first_acc, LAT + 2);
        drain(0);

        // Reset four cycles into a decryption, then vector 1 again.
        send(ks1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, 4'h3);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send(ks1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, 4'h6);
        drain(0);

        // Random key/plaintext round trips.
        for (int i = 0; i < 1000; i++) begin
            present_random();
            send(i_key_schedule, i_cipher_text, cur_pt, i_tag);
            drain(int'($urandom_range(0, 2)));
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
